// File: rtl/mem_port_adapter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_adapter
// Description : Registered bridge from the byte-addressed core memory port to
//               a word-aligned physical memory port, with legality checks and
//               a hung-memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_adapter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       mem_rdata_q;
    logic              mem_resp_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [31:0]       pmem_address_q;
    logic [31:0]       pmem_wdata_q;
    logic [3:0]        pmem_byte_enable_q;
    logic              err_q;

    logic              illegal_d;
    logic [31:0]       address_d;
    logic [31:0]       wdata_d;
    logic [3:0]        byte_enable_d;

    always_comb begin
        address_d     = {mem_address[31:2], 2'b00};
        wdata_d       = mem_wdata << {mem_address[1:0], 3'b000};
        byte_enable_d = mem_byte_enable << mem_address[1:0];
        illegal_d     = 1'b0;
        if (mem_read && mem_write) begin
            illegal_d = 1'b1;
        end else if (mem_read) begin
            illegal_d = (mem_address[1:0] != 2'b00);
        end else if (mem_write) begin
            // sb is legal at any offset; sh must not straddle a halfword
            illegal_d = ((mem_byte_enable == 4'b0011) && mem_address[0]) ||
                        ((mem_byte_enable == 4'b1111) && (mem_address[1:0] != 2'b00));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            mem_rdata_q        <= '0;
            mem_resp_q         <= 1'b0;
            pmem_read_q        <= 1'b0;
            pmem_write_q       <= 1'b0;
            pmem_address_q     <= '0;
            pmem_wdata_q       <= '0;
            pmem_byte_enable_q <= '0;
            err_q              <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        if (illegal_d) begin
                            err_q       <= 1'b1;
                            mem_rdata_q <= '0;
                            mem_resp_q  <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            pmem_read_q        <= mem_read;
                            pmem_write_q       <= mem_write;
                            pmem_address_q     <= address_d;
                            pmem_wdata_q       <= wdata_d;
                            pmem_byte_enable_q <= byte_enable_d;
                            cnt_q              <= '0;
                            state_q            <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // A response on the final allowed cycle beats the timeout
                    if (pmem_resp) begin
                        if (pmem_read_q) begin
                            mem_rdata_q <= pmem_rdata;
                        end
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        mem_resp_q   <= 1'b1;
                        state_q      <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        mem_rdata_q  <= '0;
                        err_q        <= 1'b1;
                        mem_resp_q   <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    mem_resp_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rdata        = mem_rdata_q;
    assign mem_resp         = mem_resp_q;
    assign pmem_read        = pmem_read_q;
    assign pmem_write       = pmem_write_q;
    assign pmem_address     = pmem_address_q;
    assign pmem_wdata       = pmem_wdata_q;
    assign pmem_byte_enable = pmem_byte_enable_q;
    assign err              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_adapter
// Description : Self-checking bench for mem_port_adapter with a transaction
//               level reference model and randomized requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_adapter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        pmem_read, pmem_write;
    logic [31:0] pmem_address, pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic        err_m;
    logic [31:0] rdata_m;

    always #5 clk = ~clk;

    mem_port_adapter #(.TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .err             (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        step();
        step();
        rst = 1'b0;
        err_m = 1'b0;
        rdata_m = '0;
    endtask

    // One core transaction; memory answers at cycle k (k > T means no answer in time).
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input int k,
                          input logic [31:0] rdv, input logic drop_early);
        int          off;
        int          bi;
        int          resp_c;
        bit          ill;
        bit          st;
        logic [31:0] exp_a, exp_wd;
        logic [3:0]  exp_be;
        off    = int'(addr[1:0]);
        exp_a  = addr - 32'(off);
        exp_wd = wd * (32'd1 << (8 * off));
        bi     = int'(be) * (1 << off);
        exp_be = bi[3:0];
        ill = (rd && wr) || (rd && off != 0) ||
              (wr && be == 4'b0011 && (off % 2) == 1) ||
              (wr && be == 4'b1111 && off != 0);
        if (ill)        resp_c = 1;
        else if (k <= T) resp_c = k + 1;
        else            resp_c = T + 1;

        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = wd;
        mem_byte_enable = be;
        step();
        for (int c = 1; c <= resp_c; c++) begin
            st = !ill && (c < resp_c);
            checks++;
            if (pmem_read !== (st && rd) || pmem_write !== (st && wr)) begin
                errors++;
                $display("FAIL strobe cyc=%0d got r=%b w=%b want r=%b w=%b", c,
                         pmem_read, pmem_write, st && rd, st && wr);
            end
            if (st) begin
                checks++;
                if (pmem_address !== exp_a || pmem_wdata !== exp_wd || pmem_byte_enable !== exp_be) begin
                    errors++;
                    $display("FAIL pmem_fields cyc=%0d got a=%h d=%h be=%b want a=%h d=%h be=%b", c,
                             pmem_address, pmem_wdata, pmem_byte_enable, exp_a, exp_wd, exp_be);
                end
            end
            checks++;
            if (mem_resp !== (c == resp_c)) begin
                errors++;
                $display("FAIL mem_resp cyc=%0d got %b want %b", c, mem_resp, c == resp_c);
            end
            if (c == resp_c) begin
                if (ill || k > T) begin
                    err_m = 1'b1;
                    rdata_m = '0;
                end else if (rd) begin
                    rdata_m = rdv;
                end
            end
            checks++;
            if (mem_rdata !== rdata_m || err !== err_m) begin
                errors++;
                $display("FAIL rdata_err cyc=%0d got d=%h e=%b want d=%h e=%b", c,
                         mem_rdata, err, rdata_m, err_m);
            end
            pmem_resp = (c == k);
            pmem_rdata = (c == k) ? rdv : $urandom;
            if (c == 1 && drop_early && !ill) begin
                mem_read = 1'b0;
                mem_write = 1'b0;
            end
            step();
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL idle_after got resp=%b r=%b w=%b want 0", mem_resp, pmem_read, pmem_write);
        end
    endtask

    task automatic test_reset();
        mem_address = '0;
        mem_wdata = '0;
        mem_byte_enable = '0;
        pmem_rdata = '0;
        apply_reset();
        checks++;
        if ({mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
             pmem_byte_enable, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%h resp=%b r=%b w=%b a=%h d=%h be=%b e=%b want all 0",
                     mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
                     pmem_byte_enable, err);
        end
    endtask

    task automatic test_lw();
        do_txn(1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_sb();
        do_txn(1'b0, 1'b1, 32'h0000_2003, 32'h0000_00A5, 4'b0001, 1, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_illegal();
        do_txn(1'b0, 1'b1, 32'h0000_2001, 32'h0000_BEEF, 4'b0011, 1, 32'h0, 1'b0);
        do_txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 1'b0);
        do_txn(1'b1, 1'b1, 32'h0000_3004, 32'h0, 4'hF, 1, 32'h0, 1'b0);
        apply_reset();
    endtask

    task automatic test_timeout();
        do_txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, T + 1, 32'h5555_AAAA, 1'b0);
        apply_reset();
        do_txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, T, 32'h0BAD_CAFE, 1'b0);
    endtask

    task automatic test_reset_busy();
        mem_read = 1'b1;
        mem_address = 32'h0000_5000;
        mem_byte_enable = 4'hF;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_read = 1'b0;
        err_m = 1'b0;
        rdata_m = '0;
        checks++;
        if ({mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
             pmem_byte_enable, err} !== '0) begin
            errors++;
            $display("FAIL reset_busy got resp=%b r=%b a=%h e=%b want all 0",
                     mem_resp, pmem_read, pmem_address, err);
        end
        pmem_resp = 1'b1;
        pmem_rdata = 32'hFFFF_FFFF;
        step();
        pmem_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL late_resp got resp=%b d=%h want 0", mem_resp, mem_rdata);
        end
        do_txn(1'b1, 1'b0, 32'h0000_5004, 32'h0, 4'hF, 2, 32'h7777_0001, 1'b0);
    endtask

    task automatic test_idle_resp();
        pmem_resp = 1'b1;
        pmem_rdata = 32'hA5A5_A5A5;
        step();
        pmem_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b0 || mem_rdata !== rdata_m) begin
            errors++;
            $display("FAIL idle_resp got resp=%b d=%h want 0 %h", mem_resp, mem_rdata, rdata_m);
        end
    endtask

    task automatic test_back_to_back();
        do_txn(1'b0, 1'b1, 32'h0000_6002, 32'h0000_1234, 4'b0011, 1, 32'h0, 1'b1);
        do_txn(1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 1, 32'h0000_3412, 1'b1);
        do_txn(1'b0, 1'b1, 32'h0000_6004, 32'h8765_4321, 4'hF, 2, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] bes [3];
        logic       rd, wr;
        int         r;
        bes[0] = 4'b0001;
        bes[1] = 4'b0011;
        bes[2] = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            rd = (r == 0) || (r < 5);
            wr = (r == 0) || (r >= 5);
            if (err_m && $urandom_range(0, 1) == 1) apply_reset();
            do_txn(rd, wr, $urandom, $urandom, rd ? 4'hF : bes[$urandom_range(0, 2)],
                   $urandom_range(1, T + 2), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        test_reset();
        test_lw();
        test_sb();
        test_idle_resp();
        test_illegal();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
